// File: rtl/fusion_accumulator.sv
// Unpacks fused-unit product words into 1/2/4 lanes and accumulates them per group
// with per-lane saturation, then hands the sums to writeback over valid/ready.
//
// state    | meaning
// ST_IDLE  | no group open; next legal beat starts a group
// ST_ACCUM | group open; beats must match the latched cfg/signedness
module fusion_accumulator #(
  parameter int ACC_W = 32,
  parameter int CNT_W = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [63:0]          in_data,
  input  logic [3:0]           in_cfg,
  input  logic                 in_signed,
  input  logic                 in_last,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [4*ACC_W-1:0]   out_data,
  output logic [2:0]           out_lanes,
  output logic [CNT_W-1:0]     out_beats,
  output logic                 out_sat,
  output logic                 err
);

  typedef enum logic {ST_IDLE = 1'b0, ST_ACCUM = 1'b1} state_t;

  localparam logic [CNT_W-1:0] ONE_BEAT = CNT_W'(1);

  state_t               r_state, w_state_nxt;
  logic [ACC_W-1:0]     r_acc [4];
  logic [3:0]           r_cfg;
  logic                 r_signed;
  logic [CNT_W-1:0]     r_beats;
  logic                 r_sat_grp;
  logic                 r_out_valid;
  logic [4*ACC_W-1:0]   r_out_data;
  logic [2:0]           r_out_lanes;
  logic [CNT_W-1:0]     r_out_beats;
  logic                 r_out_sat;
  logic                 r_err;

  logic                 w_accept, w_take, w_drop, w_load, w_illegal, w_mismatch;
  logic [2:0]           w_lane_cnt;
  logic [ACC_W-1:0]     w_lane [4];
  logic [ACC_W-1:0]     w_base [4];
  logic [ACC_W:0]       w_wide [4];
  logic [ACC_W-1:0]     w_sum  [4];
  logic [3:0]           w_clamp;
  logic [CNT_W-1:0]     w_beats_nxt;
  logic                 w_sat_nxt;

  assign w_illegal  = (in_cfg[3:2] == 2'b11) || (in_cfg[1:0] == 2'b11);
  assign w_mismatch = (r_state == ST_ACCUM) && ((in_cfg != r_cfg) || (in_signed != r_signed));

  always_ff @(posedge clk) begin
    if (reset) r_state <= ST_IDLE;
    else       r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE:  if (w_take && !in_last) w_state_nxt = ST_ACCUM;
      ST_ACCUM: if (w_take && in_last)  w_state_nxt = ST_IDLE;
      default:  w_state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    in_ready = !reset && (!r_out_valid || out_ready);
    w_accept = in_valid && in_ready;
    w_take   = w_accept && !w_illegal && !w_mismatch;
    w_drop   = w_accept && !w_take;
    w_load   = w_take && in_last;
  end

  // Lane unpack; lanes outside the active set stay 0 so their accumulators never move.
  always_comb begin
    w_lane_cnt = 3'd4;
    for (int k = 0; k < 4; k++) w_lane[k] = '0;
    case (in_cfg)
      4'b1010: begin
        w_lane_cnt = 3'd1;
        w_lane[0]  = {{(ACC_W-16){in_signed & in_data[15]}}, in_data[15:0]};
      end
      4'b1001, 4'b0110: begin
        w_lane_cnt = 3'd2;
        w_lane[0]  = {{(ACC_W-12){in_signed & in_data[11]}}, in_data[11:0]};
        w_lane[1]  = {{(ACC_W-12){in_signed & in_data[43]}}, in_data[43:32]};
      end
      default: begin
        for (int k = 0; k < 4; k++)
          w_lane[k] = {{(ACC_W-16){in_signed & in_data[16*k+15]}}, in_data[16*k +: 16]};
      end
    endcase
  end

  // One extra bit of headroom: signed overflow shows as the top two bits disagreeing.
  always_comb begin
    for (int k = 0; k < 4; k++) begin
      w_base[k]  = (r_state == ST_ACCUM) ? r_acc[k] : '0;
      w_wide[k]  = {in_signed & w_base[k][ACC_W-1], w_base[k]} +
                   {in_signed & w_lane[k][ACC_W-1], w_lane[k]};
      w_sum[k]   = w_wide[k][ACC_W-1:0];
      w_clamp[k] = 1'b0;
      if (in_signed) begin
        if (w_wide[k][ACC_W] != w_wide[k][ACC_W-1]) begin
          w_clamp[k] = 1'b1;
          w_sum[k]   = w_wide[k][ACC_W] ? {1'b1, {(ACC_W-1){1'b0}}} : {1'b0, {(ACC_W-1){1'b1}}};
        end
      end else if (w_wide[k][ACC_W]) begin
        w_clamp[k] = 1'b1;
        w_sum[k]   = '1;
      end
    end
    if (r_state == ST_IDLE) w_beats_nxt = ONE_BEAT;
    else if (&r_beats)      w_beats_nxt = r_beats;
    else                    w_beats_nxt = r_beats + ONE_BEAT;
    w_sat_nxt = ((r_state == ST_ACCUM) && r_sat_grp) || (|w_clamp);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int k = 0; k < 4; k++) r_acc[k] <= '0;
      r_cfg       <= '0;
      r_signed    <= 1'b0;
      r_beats     <= '0;
      r_sat_grp   <= 1'b0;
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
      r_out_lanes <= '0;
      r_out_beats <= '0;
      r_out_sat   <= 1'b0;
      r_err       <= 1'b0;
    end else begin
      if (w_drop) r_err <= 1'b1;
      if (r_out_valid && out_ready) r_out_valid <= 1'b0;
      if (w_take) begin
        r_cfg    <= in_cfg;
        r_signed <= in_signed;
        if (w_load) begin
          for (int k = 0; k < 4; k++) r_acc[k] <= '0;
          r_beats     <= '0;
          r_sat_grp   <= 1'b0;
          r_out_valid <= 1'b1;
          r_out_data  <= {w_sum[3], w_sum[2], w_sum[1], w_sum[0]};
          r_out_lanes <= w_lane_cnt;
          r_out_beats <= w_beats_nxt;
          r_out_sat   <= w_sat_nxt;
        end else begin
          for (int k = 0; k < 4; k++) r_acc[k] <= w_sum[k];
          r_beats   <= w_beats_nxt;
          r_sat_grp <= w_sat_nxt;
        end
      end
    end
  end

  assign out_valid = r_out_valid;
  assign out_data  = r_out_data;
  assign out_lanes = r_out_lanes;
  assign out_beats = r_out_beats;
  assign out_sat   = r_out_sat;
  assign err       = r_err;

endmodule

// File: tb/tb_fusion_accumulator.sv
// Directed bench for fusion_accumulator: a 32-bit and a 20-bit accumulator
// instance share one stimulus stream; expectations are hand-computed.
module tb_fusion_accumulator;

  logic         clk = 1'b0;
  logic         reset, in_valid, in_signed, in_last, out_ready;
  logic [63:0]  in_data;
  logic [3:0]   in_cfg;

  logic         rdy32, val32, sat32, err32;
  logic [127:0] dat32;
  logic [2:0]   nl32;
  logic [15:0]  bt32;
  logic         rdy20, val20, sat20, err20;
  logic [79:0]  dat20;
  logic [2:0]   nl20;
  logic [15:0]  bt20;

  always #5 clk = ~clk;

  fusion_accumulator #(.ACC_W(32), .CNT_W(16)) u_dut32 (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(rdy32), .in_data(in_data),
    .in_cfg(in_cfg), .in_signed(in_signed), .in_last(in_last), .out_valid(val32),
    .out_ready(out_ready), .out_data(dat32), .out_lanes(nl32), .out_beats(bt32),
    .out_sat(sat32), .err(err32));

  fusion_accumulator #(.ACC_W(20), .CNT_W(16)) u_dut20 (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(rdy20), .in_data(in_data),
    .in_cfg(in_cfg), .in_signed(in_signed), .in_last(in_last), .out_valid(val20),
    .out_ready(out_ready), .out_data(dat20), .out_lanes(nl20), .out_beats(bt20),
    .out_sat(sat20), .err(err20));

  typedef struct packed {
    logic [3:0]   cfg;
    logic         sgn;
    logic [63:0]  data;
    logic         last;
    logic         chk;
    logic [127:0] exp_data;
    logic [2:0]   exp_lanes;
    logic [15:0]  exp_beats;
  } vec_t;

  vec_t tbl [9];
  int   n_checks = 0;
  int   n_fail   = 0;

  function automatic vec_t mk(input logic [3:0] cfg, input logic sgn, input logic [63:0] data,
                              input logic last, input logic chk, input logic [127:0] exp_data,
                              input logic [2:0] exp_lanes, input logic [15:0] exp_beats);
    vec_t v;
    v.cfg = cfg; v.sgn = sgn; v.data = data; v.last = last; v.chk = chk;
    v.exp_data = exp_data; v.exp_lanes = exp_lanes; v.exp_beats = exp_beats;
    return v;
  endfunction

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual=0x%0h required=0x%0h", name, act, exp);
    end
  endtask

  task automatic beat(input logic [3:0] cfg, input logic sgn, input logic [63:0] data, input logic last);
    in_valid = 1'b1; in_cfg = cfg; in_signed = sgn; in_data = data; in_last = last;
    @(posedge clk); #1;
    in_valid = 1'b0; in_last = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b1; in_valid = 1'b0; in_last = 1'b0; out_ready = 1'b1;
    @(posedge clk); #1;
    chk("rst_in_ready", rdy32, 1'b0);
    chk("rst_valid",    val32, 1'b0);
    chk("rst_data",     dat32, '0);
    chk("rst_lanes",    nl32,  '0);
    chk("rst_beats",    bt32,  '0);
    chk("rst_sat",      sat32, 1'b0);
    chk("rst_err",      err32, 1'b0);
    @(posedge clk); #1;
    reset = 1'b0; #1;
    chk("post_rst_in_ready", rdy32, 1'b1);
  endtask

  task automatic sat_group(input logic sgn, input logic [15:0] val, input logic [127:0] exp32,
                           input logic [79:0] exp20);
    for (int i = 0; i < 17; i++) beat(4'b1010, sgn, {48'h0, val}, i == 16);
    chk("sat20_data",  dat20, exp20);
    chk("sat20_sat",   sat20, 1'b1);
    chk("sat20_beats", bt20,  16'd17);
    chk("sat32_data",  dat32, exp32);
    chk("sat32_sat",   sat32, 1'b0);
  endtask

  initial begin
    reset = 1'b1; in_valid = 1'b0; in_signed = 1'b0; in_last = 1'b0;
    in_data = '0; in_cfg = '0; out_ready = 1'b1;

    tbl[0] = mk(4'b1010, 1, 64'h0000_0000_0000_FFFE, 0, 0, '0, 3'd0, 16'd0);
    tbl[1] = mk(4'b1010, 1, 64'h0000_0000_0000_0005, 0, 0, '0, 3'd0, 16'd0);
    tbl[2] = mk(4'b1010, 1, 64'h0000_0000_0000_0003, 1, 1, 128'h6, 3'd1, 16'd3);
    tbl[3] = mk(4'b0101, 0, 64'h0004_0003_0002_0001, 0, 0, '0, 3'd0, 16'd0);
    tbl[4] = mk(4'b0101, 0, 64'h0004_0003_0002_0001, 1, 1,
                128'h00000008_00000006_00000004_00000002, 3'd4, 16'd2);
    tbl[5] = mk(4'b1001, 1, 64'h0000_0002_0000_0FFF, 1, 1,
                128'h00000000_00000000_00000002_FFFFFFFF, 3'd2, 16'd1);
    tbl[6] = mk(4'b0110, 0, 64'hABCD_F002_1234_5FFF, 1, 1,
                128'h00000000_00000000_00000002_00000FFF, 3'd2, 16'd1);
    tbl[7] = mk(4'b0000, 1, 64'h8000_7FFF_FFFF_0001, 1, 1,
                128'hFFFF8000_00007FFF_FFFFFFFF_00000001, 3'd4, 16'd1);
    tbl[8] = mk(4'b1010, 0, 64'h1111_2222_3333_FFFF, 1, 1, 128'h0000FFFF, 3'd1, 16'd1);

    do_reset();

    for (int i = 0; i < 9; i++) begin
      beat(tbl[i].cfg, tbl[i].sgn, tbl[i].data, tbl[i].last);
      chk($sformatf("tbl%0d_valid", i), val32, tbl[i].chk);
      if (tbl[i].chk) begin
        chk($sformatf("tbl%0d_data", i),  dat32, tbl[i].exp_data);
        chk($sformatf("tbl%0d_lanes", i), nl32,  tbl[i].exp_lanes);
        chk($sformatf("tbl%0d_beats", i), bt32,  tbl[i].exp_beats);
        chk($sformatf("tbl%0d_sat", i),   sat32, 1'b0);
      end
    end
    @(posedge clk); #1;
    chk("tbl_drain_valid", val32, 1'b0);

    // Saturation: 17 beats overflow the 20-bit accumulator but not the 32-bit one.
    sat_group(1'b1, 16'h7FFF, 128'h87FEF,    80'h7FFFF);
    sat_group(1'b0, 16'hFFFF, 128'h10FFEF,   80'hFFFFF);
    sat_group(1'b1, 16'h8000, 128'hFFF78000, 80'h80000);
    @(posedge clk); #1;

    // Backpressure: result held, input stalled, then a one-cycle release.
    out_ready = 1'b0;
    beat(4'b1010, 1'b0, 64'h9, 1'b1);
    chk("bp_valid", val32, 1'b1);
    chk("bp_in_ready", rdy32, 1'b0);
    in_valid = 1'b1; in_cfg = 4'b1010; in_signed = 1'b0; in_data = 64'h4; in_last = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      chk($sformatf("bp_hold%0d_data", i), dat32, 128'h9);
      chk($sformatf("bp_hold%0d_rdy", i), rdy32, 1'b0);
    end
    out_ready = 1'b1; #1;
    chk("bp_release_in_ready", rdy32, 1'b1);
    @(posedge clk); #1;
    out_ready = 1'b0;
    chk("bp_consumed_valid", val32, 1'b0);
    in_data = 64'h6; in_last = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0; in_last = 1'b0;
    chk("bp_next_valid", val32, 1'b1);
    chk("bp_next_data",  dat32, 128'hA);
    chk("bp_next_beats", bt32,  16'd2);
    out_ready = 1'b1;
    @(posedge clk); #1;
    chk("bp_final_valid", val32, 1'b0);

    // Mismatched and illegal beats are dropped and flag err.
    do_reset();
    beat(4'b1010, 1'b1, 64'h10, 1'b0);
    beat(4'b0101, 1'b1, 64'h0001_0001_0001_0001, 1'b1);
    chk("mm_cfg_err",   err32, 1'b1);
    chk("mm_cfg_valid", val32, 1'b0);
    beat(4'b1010, 1'b0, 64'h100, 1'b1);
    chk("mm_sgn_valid", val32, 1'b0);
    beat(4'b1010, 1'b1, 64'h20, 1'b1);
    chk("mm_valid", val32, 1'b1);
    chk("mm_data",  dat32, 128'h30);
    chk("mm_beats", bt32,  16'd2);
    do_reset();
    beat(4'b1100, 1'b0, 64'h5, 1'b1);
    chk("ill_err",   err32, 1'b1);
    chk("ill_valid", val32, 1'b0);
    beat(4'b1010, 1'b0, 64'h1, 1'b1);
    chk("ill_after_data",  dat32, 128'h1);
    chk("ill_after_beats", bt32,  16'd1);
    chk("ill_err_sticky",  err32, 1'b1);

    // Reset in the middle of a group discards the partial sums.
    do_reset();
    for (int i = 0; i < 3; i++) beat(4'b1010, 1'b0, 64'h1, 1'b0);
    do_reset();
    @(posedge clk); #1;
    chk("midrst_valid", val32, 1'b0);
    beat(4'b1010, 1'b0, 64'h7, 1'b1);
    chk("midrst_next_valid", val32, 1'b1);
    chk("midrst_next_data",  dat32, 128'h7);
    chk("midrst_next_beats", bt32,  16'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
